// File: rtl/exa_crosb_vc_pkg.sv
// Shared types and default sizing for the VC crossbar credit tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exa_crosb_vc_pkg;

   // Index width for a channel select; a single channel still needs one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int def_output_num = 2;
   localparam int def_vc_num     = 2;
   localparam int def_prio_num   = 2;
   localparam int def_credit_max = 4;
   localparam int chan_num       = def_vc_num * def_prio_num;
   localparam int logVcPrio      = idx_width(chan_num);

   // Per-output packet framing state.
   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } pkt_state_t;

endpackage

// File: rtl/exa_crosb_credit_counter.sv
// Saturating packet-credit counter for one (output, channel) pair.
// Latency: count updates on the clock after consume/return; error pulses are same-cycle.
// Backpressure: none; it only observes consume/return strobes.
module exa_crosb_credit_counter #(
   parameter int credit_max   = 4,
   parameter int credit_width = $clog2(credit_max + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    consume,
   input  logic                    credit_return,
   output logic [credit_width-1:0] count,
   output logic                    underflow,
   output logic                    overflow
);

   logic at_zero;
   logic at_max;

   assign at_zero = (count == '0);
   assign at_max  = (count == credit_width'(credit_max));

   // A simultaneous consume and return cancel; otherwise step and saturate at the bounds.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= credit_width'(credit_max);
      end else if (consume && !credit_return && !at_zero) begin
         count <= count - credit_width'(1);
      end else if (credit_return && !consume && !at_max) begin
         count <= count + credit_width'(1);
      end
   end

   // Attempts to step past a bound are reported rather than wrapped.
   always_comb begin
      underflow = consume && !credit_return && at_zero;
      overflow  = credit_return && !consume && at_max;
   end

endmodule

// File: rtl/exa_crosb_vc_credit_tracker.sv
// Per-(output, VC) downstream packet-credit tracking with sticky protocol error flags.
// Latency: counters, credit bits and error flags change one clock after the triggering beat/return.
// Backpressure: none; passively observes accepted beats (tvalid & tready) and return pulses.
module exa_crosb_vc_credit_tracker
   import exa_crosb_vc_pkg::*;
#(
   parameter int output_num   = def_output_num,
   parameter int vc_num       = def_vc_num,
   parameter int prio_num     = def_prio_num,
   parameter int credit_max   = def_credit_max,
   parameter int chan_cnt     = vc_num * prio_num,
   parameter int vc_w         = idx_width(vc_num * prio_num),
   parameter int credit_width = $clog2(credit_max + 1)
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic [output_num-1:0]                             i_tvalid,
   input  logic [output_num-1:0]                             i_tready,
   input  logic [output_num-1:0]                             i_tlast,
   input  logic [output_num-1:0][vc_w-1:0]                   i_vc,
   input  logic [output_num-1:0][chan_cnt-1:0]               i_credit_return,
   input  logic                                              i_clear_err,
   output logic [output_num-1:0][chan_cnt-1:0]               o_output_fifo_credits,
   output logic [output_num-1:0][chan_cnt-1:0][credit_width-1:0] o_credit_count,
   output logic [output_num-1:0]                             o_err_underflow,
   output logic [output_num-1:0]                             o_err_overflow
);

   pkt_state_t                          state_q [output_num];
   pkt_state_t                          state_d [output_num];
   logic [output_num-1:0]               beat;
   logic [output_num-1:0]               pkt_start;
   logic [output_num-1:0][chan_cnt-1:0] uf_pulse;
   logic [output_num-1:0][chan_cnt-1:0] of_pulse;

   assign beat = i_tvalid & i_tready;

   // Packet framing state per output; reset abandons any packet in flight.
   always_ff @(posedge clk) begin
      for (int o = 0; o < output_num; o++) begin
         if (reset) begin
            state_q[o] <= IDLE;
         end else begin
            state_q[o] <= state_d[o];
         end
      end
   end

   // Only the first accepted beat of a packet takes a credit; i_vc is ignored afterwards.
   always_comb begin
      for (int o = 0; o < output_num; o++) begin
         state_d[o]   = state_q[o];
         pkt_start[o] = 1'b0;
         case (state_q[o])
            IDLE: begin
               if (beat[o]) begin
                  pkt_start[o] = 1'b1;
                  if (!i_tlast[o]) begin
                     state_d[o] = IN_PKT;
                  end
               end
            end
            IN_PKT: begin
               if (beat[o] && i_tlast[o]) begin
                  state_d[o] = IDLE;
               end
            end
            default: state_d[o] = IDLE;
         endcase
      end
   end

   for (genvar o = 0; o < output_num; o++) begin : g_out
      for (genvar v = 0; v < chan_cnt; v++) begin : g_chan
         logic consume;

         assign consume = pkt_start[o] && (i_vc[o] == vc_w'(v));

         exa_crosb_credit_counter #(
            .credit_max   (credit_max),
            .credit_width (credit_width)
         ) u_cnt (
            .clk           (clk),
            .reset         (reset),
            .consume       (consume),
            .credit_return (i_credit_return[o][v]),
            .count         (o_credit_count[o][v]),
            .underflow     (uf_pulse[o][v]),
            .overflow      (of_pulse[o][v])
         );

         assign o_output_fifo_credits[o][v] = (o_credit_count[o][v] != '0);
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      for (int o = 0; o < output_num; o++) begin
         if (reset) begin
            o_err_underflow[o] <= 1'b0;
            o_err_overflow[o]  <= 1'b0;
         end else begin
            if (|uf_pulse[o]) begin
               o_err_underflow[o] <= 1'b1;
            end else if (i_clear_err) begin
               o_err_underflow[o] <= 1'b0;
            end
            if (|of_pulse[o]) begin
               o_err_overflow[o] <= 1'b1;
            end else if (i_clear_err) begin
               o_err_overflow[o] <= 1'b0;
            end
         end
      end
   end

endmodule
